jump_encoder: RTL

Pipelined J-type instruction encoder: the inverse of the jump address path. It takes a jump target address and the address of the jump instruction, then produces the 32-bit J or JAL instruction word carrying the 26-bit instruction index. It flags targets that the CPU's jump address logic cannot reach. It sits in the test/boot infrastructure beside the CPU and feeds instruction words to the memory-image writer over a valid/ready stream.

---
 rtl/mips_pkg.sv | 18 +
 rtl/jump_field_encode.sv | 25 ++
 rtl/jump_encoder.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and the encoded-word payload for the J-type jump encoder.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ERR_W   = 2;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;

  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_REGION   = 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ERR_W-1:0]   err;
  } jword_t;

endpackage

// File: rtl/jump_field_encode.sv
// Combinational J/JAL field packer: builds the instruction word and advisory error flags.
module jump_field_encode
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] target,
  input  logic        link,
  output jword_t      word_c
);

  logic [31:0] pc4;
  logic        unused_pc4_low;

  // Carry out of bit 31 is dropped, so pc4 wraps at the top of the address space.
  assign pc4            = pc + 32'd4;
  assign unused_pc4_low = ^pc4[27:0];

  always_comb begin
    word_c                   = '0;
    word_c.instr             = {(link ? OPC_JAL : OPC_J), target[27:2]};
    word_c.err[ERR_MISALIGN] = |target[1:0];
    word_c.err[ERR_REGION]   = (pc4[31:28] != target[31:28]);
  end

endmodule

// File: rtl/jump_encoder.sv
// Pipelined J-type encoder: one encode stage feeding a main+skid output buffer
// with a registered in_ready and a saturating count of flagged words.
module jump_encoder
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_target,
  input  logic             in_link,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  jword_t           enc_c;
  jword_t           main_q, main_d;
  jword_t           skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             drain;

  jump_field_encode u_enc (
    .pc     (in_pc),
    .target (in_target),
    .link   (in_link),
    .word_c (enc_c)
  );

  assign accept = in_valid & in_ready_q;
  assign drain  = main_vld_q & out_ready;

  // Buffer steering and counter next-state.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;

    if (skid_vld_q) begin
      if (drain) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q || drain) begin
        main_d     = enc_c;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = enc_c;
        skid_vld_d = 1'b1;
      end
    end else if (drain) begin
      main_vld_d = 1'b0;
    end

    if (drain && (|main_q.err) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= ~skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_instr = main_q.instr;
  assign out_err   = main_q.err;
  assign err_count = cnt_q;

endmodule
